// File: rtl/width_upsizer.sv
// Packs narrow IN_WIDTH beats into RATIO-lane words with a lane-keep mask;
// i_last closes a word early so packet tails flush as partial words.
module width_upsizer #(
    parameter  int IN_WIDTH  = 8,
    parameter  int RATIO     = 4,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                 i_clock,
    input  logic                 i_aresetn,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic                 i_last,
    input  logic                 i_input_valid,
    output logic                 o_input_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic [RATIO-1:0]     o_keep,
    output logic                 o_last,
    output logic                 o_output_valid,
    input  logic                 i_output_ready
);

    localparam int CNT_W = $clog2(RATIO);

    // One-hot style encoding leaves spare codes that recover to FILL.
    typedef enum logic [1:0] {
        FILL = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     count, count_n;
    logic [OUT_WIDTH-1:0] data_n;
    logic [RATIO-1:0]     keep_n;
    logic                 last_n;
    logic                 ready_en;
    logic                 accept;
    logic                 transmit;

    // In HOLD, downstream ready passes straight through so a new beat can
    // enter in the same cycle the held word leaves.
    assign o_input_ready  = (state == HOLD) ? i_output_ready
                                            : ((state == FILL) && ready_en);
    assign o_output_valid = (state == HOLD);
    assign accept         = i_input_valid && o_input_ready;
    assign transmit       = o_output_valid && i_output_ready;

    always_comb begin
        state_n = state;
        count_n = count;
        data_n  = o_data;
        keep_n  = o_keep;
        last_n  = o_last;
        unique case (state)
            FILL: begin
                if (accept) begin
                    for (int k = 0; k < RATIO; k++) begin
                        if (count == CNT_W'(k)) begin
                            data_n[k*IN_WIDTH +: IN_WIDTH] = i_data;
                            keep_n[k]                      = 1'b1;
                        end
                    end
                    if ((count == CNT_W'(RATIO - 1)) || i_last) begin
                        state_n = HOLD;
                        last_n  = i_last;
                        count_n = '0;
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (transmit && accept) begin
                    data_n = OUT_WIDTH'(i_data);
                    keep_n = RATIO'(1);
                    if (i_last) begin
                        state_n = HOLD;
                        last_n  = 1'b1;
                        count_n = '0;
                    end else begin
                        state_n = FILL;
                        last_n  = 1'b0;
                        count_n = CNT_W'(1);
                    end
                end else if (transmit) begin
                    data_n  = '0;
                    keep_n  = '0;
                    last_n  = 1'b0;
                    state_n = FILL;
                    count_n = '0;
                end
            end
            default: begin
                state_n = FILL;
                count_n = '0;
                data_n  = '0;
                keep_n  = '0;
                last_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state    <= FILL;
            count    <= '0;
            o_data   <= '0;
            o_keep   <= '0;
            o_last   <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_n;
            count    <= count_n;
            o_data   <= data_n;
            o_keep   <= keep_n;
            o_last   <= last_n;
            ready_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_width_upsizer.sv
// Directed table, stall/reset sequences and a randomised scoreboard run
// for width_upsizer with IN_WIDTH=8, RATIO=4.
module tb_width_upsizer;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        in_vld = 1'b0;
    logic        irdy;
    logic [31:0] o_data;
    logic [3:0]  o_keep;
    logic        o_last;
    logic        ovld;
    logic        ordy = 1'b0;

    int nerr = 0;
    int nchk = 0;

    width_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .i_clock        (clk),
        .i_aresetn      (aresetn),
        .i_data         (in_data),
        .i_last         (in_last),
        .i_input_valid  (in_vld),
        .o_input_ready  (irdy),
        .o_data         (o_data),
        .o_keep         (o_keep),
        .o_last         (o_last),
        .o_output_valid (ovld),
        .i_output_ready (ordy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [7:0]  d;
        logic        l;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic        chk;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic        e_last;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    vec_t        tbl [12];
    word_t       q [$];
    logic [31:0] m_data = '0;
    logic [3:0]  m_keep = '0;
    int          mcnt = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b1;
    logic [31:0] pd = '0;
    logic [3:0]  pk = '0;
    logic        pl = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
        in_vld  = v;
        in_data = d;
        in_last = l;
        ordy    = r;
    endtask

    task automatic check_word(input string nm, input logic [31:0] d, input logic [3:0] k, input logic l);
        check({nm, "_data"}, o_data, d);
        check({nm, "_keep"}, 32'(o_keep), 32'(k));
        check({nm, "_last"}, 32'(o_last), 32'(l));
    endtask

    task automatic sb_cycle(output logic acc);
        logic  tx;
        word_t w;
        acc = in_vld && irdy;
        tx  = ovld && ordy;
        check("rnd_irdy", 32'(irdy), 32'(ovld ? ordy : 1'b1));
        if (pv && !pr) begin
            check("stall_vld", 32'(ovld), 32'd1);
            check_word("stall", pd, pk, pl);
        end
        if (tx) begin
            if (q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_unexpected: got word %h expected none", o_data);
            end else begin
                w = q.pop_front();
                check_word("sb", w.d, w.k, w.l);
            end
        end
        if (acc) begin
            m_data[mcnt*8 +: 8] = in_data;
            m_keep[mcnt]        = 1'b1;
            mcnt++;
            if (mcnt == 4 || in_last) begin
                q.push_back('{d: m_data, k: m_keep, l: in_last});
                m_data = '0;
                m_keep = '0;
                mcnt   = 0;
            end
        end
        pv = ovld;
        pr = ordy;
        pd = o_data;
        pk = o_keep;
        pl = o_last;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   beats;
        int   cyc;

        //            vld   d      l     ordy  irdy  ovld  chk   data          keep     last
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        4'h0, 1'b0};
        tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[3]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[4]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0};
        tbl[6]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        4'h0, 1'b0};
        tbl[7]  = '{1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[8]  = '{1'b1, 8'h5C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000A2A1, 4'h3, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000005C, 4'h1, 1'b1};
        tbl[10] = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        4'h0, 1'b0};
        tbl[11] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        4'h0, 1'b0};

        // Reset state
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ovld", 32'(ovld), 32'd0);
        check("rst_irdy", 32'(irdy), 32'd0);
        check_word("rst", 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        aresetn = 1'b1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].vld, tbl[i].d, tbl[i].l, tbl[i].ordy);
            #1;
            check($sformatf("row%0d_irdy", i), 32'(irdy), 32'(tbl[i].e_irdy));
            check($sformatf("row%0d_ovld", i), 32'(ovld), 32'(tbl[i].e_ovld));
            if (tbl[i].chk)
                check_word($sformatf("row%0d", i), tbl[i].e_data, tbl[i].e_keep, tbl[i].e_last);
            @(negedge clk);
        end

        // Stalled word, with a beat waiting for the transmit cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hAA + 8'(i * 8'h11), 1'b0, 1'b0);
            #1;
            check("stall_fill_irdy", 32'(irdy), 32'd1);
            check("stall_fill_ovld", 32'(ovld), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hEE, 1'b0, 1'b0);
            #1;
            check("hold_ovld", 32'(ovld), 32'd1);
            check("hold_irdy", 32'(irdy), 32'd0);
            check_word("hold", 32'hDDCCBBAA, 4'hF, 1'b0);
            @(negedge clk);
        end
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        #1;
        check("release_irdy", 32'(irdy), 32'd1);
        check("release_ovld", 32'(ovld), 32'd1);
        check_word("release", 32'hDDCCBBAA, 4'hF, 1'b0);
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1);
            #1;
            check("after_irdy", 32'(irdy), 32'd1);
            check("after_ovld", 32'(ovld), 32'd0);
            @(negedge clk);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        check("lane0_ovld", 32'(ovld), 32'd1);
        check_word("lane0", 32'h030201EE, 4'hF, 1'b0);
        @(negedge clk);

        // Random traffic against the scoreboard
        beats = 0;
        cyc   = 0;
        pv    = 1'b0;
        pr    = 1'b1;
        while (beats < 64 && cyc < 3000) begin
            drive($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) != 0);
            #1;
            sb_cycle(acc);
            if (acc) beats++;
            cyc++;
            @(negedge clk);
        end
        check("rnd_beats", 32'(beats), 32'd64);
        cyc = 0;
        while ((mcnt != 0 || q.size() != 0 || ovld) && cyc < 200) begin
            drive(mcnt != 0, 8'($urandom), 1'b1, 1'b1);
            #1;
            sb_cycle(acc);
            cyc++;
            @(negedge clk);
        end
        check("drain_q", 32'(q.size()), 32'd0);
        check("drain_ovld", 32'(ovld), 32'd0);

        // Reset in the middle of a word
        drive(1'b1, 8'h01, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 8'h02, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b1, 8'h03, 1'b0, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check("midrst_ovld", 32'(ovld), 32'd0);
        check("midrst_irdy", 32'(irdy), 32'd0);
        check_word("midrst", 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        aresetn = 1'b1;
        drive(1'b1, 8'h61, 1'b0, 1'b1);
        #1;
        check("postrst_irdy", 32'(irdy), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h61 + 8'(i), 1'b0, 1'b1);
            #1;
            check("postrst_fill_irdy", 32'(irdy), 32'd1);
            check("postrst_fill_ovld", 32'(ovld), 32'd0);
            @(negedge clk);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        check("postrst_ovld", 32'(ovld), 32'd1);
        check_word("postrst", 32'h64636261, 4'hF, 1'b0);
        @(negedge clk);
        #1;
        check("postrst_idle_ovld", 32'(ovld), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
